sg_window_feeder: RTL and testbench

//  Streaming front end for the Savitzky-Golay smoother. It accepts an 8-bit sample stream over valid/ready.
//  It emits one centred WINDOW_SIZE-sample window per input sample, so N samples in give N windows out.

---
 rtl/sg_pkg.sv | 22 ++
 rtl/sg_window_shreg.sv | 32 +++
 rtl/sg_window_feeder.sv | 127 ++++++++++++
 tb/tb_sg_window_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sg_pkg.sv
// sg_pkg: shared state codes, parameter defaults and window helpers for the SG feeder
package sg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t FLUSH = 3'd3;
    localparam state_t DONE  = 3'd4;

    localparam int WINDOW_SIZE_DEF = 7;
    localparam int DATA_W_DEF      = 8;
    localparam int OUT_W_DEF       = 16;
    localparam int MAX_LEN_DEF     = 1024;

    // Number of samples on each side of the window centre.
    function automatic int half(input int w);
        return (w - 1) / 2;
    endfunction

endpackage

// File: rtl/sg_window_shreg.sv
// sg_window_shreg: WINDOW_SIZE x OUT_W window register with broadcast load and shift-in
module sg_window_shreg #(
    parameter int WINDOW_SIZE = 7,
    parameter int OUT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_all_i,
    input  logic                         shift_i,
    input  logic [OUT_W-1:0]             shift_in_i,
    output logic [WINDOW_SIZE*OUT_W-1:0] win_o
);

    logic [OUT_W-1:0] w_q [WINDOW_SIZE];

    // Load fills every slot with one sample; shift moves oldest out at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW_SIZE; i++) w_q[i] <= '0;
        end else if (load_all_i) begin
            for (int i = 0; i < WINDOW_SIZE; i++) w_q[i] <= shift_in_i;
        end else if (shift_i) begin
            for (int i = 0; i < WINDOW_SIZE - 1; i++) w_q[i] <= w_q[i+1];
            w_q[WINDOW_SIZE-1] <= shift_in_i;
        end
    end

    for (genvar g = 0; g < WINDOW_SIZE; g++) begin : g_flat
        assign win_o[g*OUT_W +: OUT_W] = w_q[g];
    end

endmodule

// File: rtl/sg_window_feeder.sv
// sg_window_feeder: turns a sample stream into one edge-replicated centred window per sample
module sg_window_feeder
    import sg_pkg::*;
#(
    parameter int WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int MAX_LEN     = MAX_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            in_data_i,
    input  logic                         in_last_i,
    output logic                         win_valid_o,
    input  logic                         win_ready_i,
    output logic [WINDOW_SIZE*OUT_W-1:0] win_data_o,
    output logic                         win_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int HALF = half(WINDOW_SIZE);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int HW   = $clog2(HALF + 2);
    localparam logic [HW-1:0] HALF_C = HW'(HALF);
    localparam logic [LW-1:0] MAX_C  = LW'(MAX_LEN);

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [HW-1:0]   shift_cnt_q, shift_cnt_d;
    logic [HW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            win_valid_q, win_valid_d;
    logic            win_last_q, win_last_d;
    logic            free, accept, flush_step, load_all, shift, emit;
    logic [OUT_W-1:0] shift_in;

    // The window register only moves when the output slot is free, so a
    // stalled window is held stable simply by not loading or shifting.
    always_comb begin
        free       = !win_valid_q || win_ready_i;
        in_ready_o = (state_q == LOAD || state_q == RUN) && free;
        accept     = in_valid_i && in_ready_o;
        flush_step = state_q == FLUSH && free && flush_cnt_q != HALF_C;
        load_all   = state_q == LOAD && accept;
        shift      = (state_q == RUN && accept) || flush_step;
        shift_in   = flush_step ? win_data_o[WINDOW_SIZE*OUT_W-1 -: OUT_W] : OUT_W'(in_data_i);
    end

    // Sequencing of a run plus the fill/flush counters that decide emission.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        shift_cnt_d = shift_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: state_d = start_i ? LOAD : IDLE;
            LOAD: if (accept) begin
                len_d       = LW'(1);
                shift_cnt_d = '0;
                flush_cnt_d = '0;
                state_d     = (in_last_i || MAX_LEN == 1) ? FLUSH : RUN;
            end
            RUN: if (accept) begin
                len_d       = len_q + LW'(1);
                shift_cnt_d = (shift_cnt_q == HALF_C) ? shift_cnt_q : shift_cnt_q + HW'(1);
                state_d     = (in_last_i || len_d == MAX_C) ? FLUSH : RUN;
            end
            FLUSH: begin
                if (flush_step) begin
                    flush_cnt_d = flush_cnt_q + HW'(1);
                    shift_cnt_d = (shift_cnt_q == HALF_C) ? shift_cnt_q : shift_cnt_q + HW'(1);
                end
                if (flush_cnt_q == HALF_C && win_valid_q && win_ready_i) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A window is ready once the centre sample has HALF samples behind it;
    // the last one is the step that completes the trailing flush.
    always_comb begin
        emit        = (load_all || shift) && shift_cnt_d == HALF_C;
        win_valid_d = emit || (win_valid_q && !win_ready_i);
        win_last_d  = emit ? (state_d == FLUSH && flush_cnt_d == HALF_C) : (win_valid_d && win_last_q);
    end

    // State and counter registers; reset aborts any run and drops the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            shift_cnt_q <= '0;
            flush_cnt_q <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            shift_cnt_q <= shift_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    sg_window_shreg #(
        .WINDOW_SIZE(WINDOW_SIZE),
        .OUT_W      (OUT_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_all_i(load_all),
        .shift_i   (shift),
        .shift_in_i(shift_in),
        .win_o     (win_data_o)
    );

    assign win_valid_o = win_valid_q;
    assign win_last_o  = win_last_q;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;

endmodule

// File: tb/tb_sg_window_feeder.sv
// tb_sg_window_feeder: directed and randomized runs checked against a centred-window model
module tb_sg_window_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0, win_ready = 1'b0, sel = 1'b0;
    logic [7:0] in_data = '0;
    logic a_in_ready, a_win_valid, a_win_last, a_busy, a_done;
    logic b_in_ready, b_win_valid, b_win_last, b_busy, b_done;
    logic [111:0] a_win_data, b_win_data;
    logic in_ready, win_valid, win_last, busy, done;
    logic [111:0] win_data;
    logic [7:0] smp[$];
    logic [111:0] cap[$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    sg_window_feeder u_dut (
        .clk(clk), .rst(rst), .start_i(start && !sel), .in_valid_i(in_valid),
        .in_ready_o(a_in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .win_valid_o(a_win_valid), .win_ready_i(win_ready), .win_data_o(a_win_data),
        .win_last_o(a_win_last), .busy_o(a_busy), .done_o(a_done)
    );

    sg_window_feeder #(.MAX_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start && sel), .in_valid_i(in_valid),
        .in_ready_o(b_in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .win_valid_o(b_win_valid), .win_ready_i(win_ready), .win_data_o(b_win_data),
        .win_last_o(b_win_last), .busy_o(b_busy), .done_o(b_done)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign win_valid = sel ? b_win_valid : a_win_valid;
    assign win_last  = sel ? b_win_last  : a_win_last;
    assign busy      = sel ? b_busy      : a_busy;
    assign done      = sel ? b_done      : a_done;
    assign win_data  = sel ? b_win_data  : a_win_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window k of an n-sample run: samples k-3..k+3 with indices clamped to the run.
    function automatic logic [111:0] exp_win(input int k, input int n);
        logic [111:0] r;
        for (int i = 0; i < 7; i++) begin
            int j;
            j = k - 3 + i;
            j = j < 0 ? 0 : (j > n - 1 ? n - 1 : j);
            r[i*16 +: 16] = {8'h00, smp[j]};
        end
        return r;
    endfunction

    function automatic logic [111:0] pack7(input int a, b, c, d, e, f, g);
        return {16'(g), 16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic ramp(input int n);
        smp.delete();
        for (int i = 1; i <= n; i++) smp.push_back(8'(i));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_win_last"}, win_last, 0);
        chk({tag, "_win_data"}, win_data, 0);
    endtask

    // mode 0: always valid/ready; 1: ready low for 4 cycles mid-run; 2: random gaps on both.
    task automatic run(input int n_off, input int maxl, input int mode, input int abort_at, input bit poke);
        int n_eff, idx, got, cyc;
        bit held, fin;
        logic [111:0] held_data;
        n_eff = n_off < maxl ? n_off : maxl;
        idx = 0; got = 0; cyc = 0; held = 0; fin = 0;
        cap.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!fin && cyc < 2000) begin
            in_valid  = idx < n_off && (mode != 2 || $urandom_range(0, 3) != 0);
            in_data   = idx < n_off ? smp[idx] : 8'h00;
            in_last   = idx == n_off - 1;
            win_ready = mode == 0 ? 1'b1 : mode == 1 ? !(cyc >= 8 && cyc < 12) : ($urandom_range(0, 2) != 0);
            start     = poke && cyc == 4;
            #1;
            chk("busy_run", busy, 1);
            chk("early_done", done, 0);
            if (held) begin
                chk("hold_data", win_data, held_data);
                chk("hold_valid", win_valid, 1);
            end
            if (win_valid && !win_ready) chk("stall_in_ready", in_ready, 0);
            if (mode == 0 && idx < n_eff) chk("throughput", in_ready, 1);
            held = win_valid && !win_ready;
            held_data = win_data;
            if (win_valid && win_ready) begin
                chk("win_data", win_data, exp_win(got, n_eff));
                chk("win_last", win_last, got == n_eff - 1);
                cap.push_back(win_data);
                got++;
                fin = got == n_eff;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #1;
                check_idle_zero("abort");
                #3 rst = 1'b0;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("abort_no_done", done, 0);
                    chk("abort_idle", busy, 0);
                end
                return;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        win_ready = 1'b1;
        chk("win_count", got, n_eff);
        chk("accepted", idx, n_eff);
        #1;
        chk("done_pulse", done, 1);
        chk("valid_after_last", win_valid, 0);
        @(negedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        ramp(10);
        run(10, 1024, 0, -1, 0);
        chk("t1_first", cap[0], pack7(1, 1, 1, 1, 2, 3, 4));
        chk("t1_fifth", cap[4], pack7(2, 3, 4, 5, 6, 7, 8));
        chk("t1_last", cap[9], pack7(7, 8, 9, 10, 10, 10, 10));

        smp.delete(); smp.push_back(8'd42);
        run(1, 1024, 0, -1, 0);
        chk("t2_single", cap[0], pack7(42, 42, 42, 42, 42, 42, 42));

        smp.delete(); smp.push_back(8'd5); smp.push_back(8'd9);
        run(2, 1024, 0, -1, 0);
        chk("t2_pair0", cap[0], pack7(5, 5, 5, 5, 9, 9, 9));
        chk("t2_pair1", cap[1], pack7(5, 5, 5, 9, 9, 9, 9));

        ramp(10);
        run(10, 1024, 1, -1, 0);
        chk("t3_last", cap[9], pack7(7, 8, 9, 10, 10, 10, 10));

        smp.delete(); smp.push_back(8'd255);
        for (int i = 0; i < 5; i++) smp.push_back(8'($urandom_range(0, 255)));
        run(6, 1024, 0, -1, 0);
        chk("t4_zext", cap[0][15:0], 16'h00FF);

        ramp(10);
        run(10, 1024, 0, 5, 0);
        ramp(10);
        run(10, 1024, 0, -1, 0);
        chk("t5_first", cap[0], pack7(1, 1, 1, 1, 2, 3, 4));
        chk("t5_last", cap[9], pack7(7, 8, 9, 10, 10, 10, 10));

        ramp(10);
        run(10, 1024, 0, -1, 1);

        sel = 1'b1;
        smp.delete();
        for (int i = 0; i < 6; i++) smp.push_back(8'($urandom_range(0, 255)));
        run(6, 4, 0, -1, 0);
        sel = 1'b0;

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 20);
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(8'($urandom_range(0, 255)));
            run(n, 1024, 2, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
